// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer: drives the CP0 register-file port to save and
// restore Status, write Cause/EPC, and redirect the PC to the handler or EPC.
module cp0_exc_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  output logic        busy,
  output logic        done,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        cp0_r,
  output logic [4:0]  cp0_raddr,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_w,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata
);

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    E_RDST  = 4'd1,
    E_WST   = 4'd2,
    E_WCA   = 4'd3,
    E_WEPC  = 4'd4,
    E_DONE  = 4'd5,
    R_RDST  = 4'd6,
    R_WST   = 4'd7,
    R_RDEPC = 4'd8,
    R_DONE  = 4'd9
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic [31:0] status_q;
  logic [31:0] epc_q;

  // State register plus capture of request operands and CP0 read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      code_q   <= 5'd0;
      pc_q     <= 32'd0;
      status_q <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && exc_req) begin
        code_q <= exc_code;
        pc_q   <= exc_pc;
      end
      if (state_q == E_RDST || state_q == R_RDST) begin
        status_q <= cp0_rdata;
      end
      if (state_q == R_RDEPC) begin
        epc_q <= cp0_rdata;
      end
    end
  end

  // Next-state and Moore output decode; unused encodings fall back to IDLE.
  always_comb begin
    state_d     = IDLE;
    busy        = 1'b0;
    done        = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    cp0_r       = 1'b0;
    cp0_raddr   = 5'd0;
    cp0_w       = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'd0;
    case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d = E_RDST;
        end else if (eret_req) begin
          state_d = R_RDST;
        end else begin
          state_d = IDLE;
        end
      end
      E_RDST: begin
        busy      = 1'b1;
        cp0_r     = 1'b1;
        cp0_raddr = CP0_STATUS;
        state_d   = E_WST;
      end
      E_WST: begin
        busy      = 1'b1;
        cp0_w     = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = status_q << 5;
        state_d   = E_WCA;
      end
      E_WCA: begin
        busy      = 1'b1;
        cp0_w     = 1'b1;
        cp0_waddr = CP0_CAUSE;
        cp0_wdata = {25'd0, code_q, 2'b00};
        state_d   = E_WEPC;
      end
      E_WEPC: begin
        busy      = 1'b1;
        cp0_w     = 1'b1;
        cp0_waddr = CP0_EPC;
        cp0_wdata = pc_q;
        state_d   = E_DONE;
      end
      E_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = EXC_VECTOR;
        state_d     = IDLE;
      end
      R_RDST: begin
        busy      = 1'b1;
        cp0_r     = 1'b1;
        cp0_raddr = CP0_STATUS;
        state_d   = R_WST;
      end
      R_WST: begin
        busy      = 1'b1;
        cp0_w     = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = status_q >> 5;
        state_d   = R_RDEPC;
      end
      R_RDEPC: begin
        busy      = 1'b1;
        cp0_r     = 1'b1;
        cp0_raddr = CP0_EPC;
        state_d   = R_DONE;
      end
      R_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed bench for cp0_exc_seq: CP0 register model, write/redirect scoreboard
// and per-cycle handshake pattern checks.
module tb_cp0_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret_req;
  logic        busy;
  logic        done;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        cp0_r;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        cp0_w;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;

  logic [31:0] regs [0:31];
  logic [37:0] exp_q [$];
  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign cp0_rdata = regs[cp0_raddr];

  cp0_exc_seq dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc),
    .eret_req(eret_req), .busy(busy), .done(done), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .cp0_r(cp0_r), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .cp0_w(cp0_w), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [79:0] all_outs();
    return {1'b0, busy, done, pc_redirect, pc_target, cp0_r, cp0_raddr, cp0_w, cp0_waddr, cp0_wdata};
  endfunction

  // One cycle: sample at the falling edge, score strobes, then commit CP0 writes.
  task automatic tick();
    logic [37:0] o;
    logic [37:0] e;
    @(negedge clk);
    check("invariants", {75'd0, cp0_r & cp0_w,
                         !cp0_w && (cp0_waddr != 5'd0 || cp0_wdata != 32'd0),
                         !cp0_r && cp0_raddr != 5'd0,
                         !pc_redirect && pc_target != 32'd0,
                         done != pc_redirect}, 80'd0);
    if (cp0_w || pc_redirect) begin
      o = cp0_w ? {1'b0, cp0_waddr, cp0_wdata} : {1'b1, 5'd0, pc_target};
      if (exp_q.size() == 0) begin
        e = 38'h3F_FFFF_FFFF;
        check("unexpected_out", {42'd0, o}, {42'd0, e});
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", {42'd0, o}, {42'd0, e});
      end
    end
    if (cp0_w) regs[cp0_waddr] = cp0_wdata;
  endtask

  task automatic run_seq(input bit is_exc, input bit both, input bit inject,
                         input logic [4:0] code, input logic [31:0] pc,
                         input logic [31:0] st, input logic [31:0] epc,
                         input logic [31:0] exp_st);
    logic [8:0] pe;
    int n;
    regs[12] = st;
    if (!is_exc) regs[14] = epc;
    exp_q.push_back({1'b0, 5'd12, exp_st});
    if (is_exc) begin
      exp_q.push_back({1'b0, 5'd13, 25'd0, code, 2'b00});
      exp_q.push_back({1'b0, 5'd14, pc});
      exp_q.push_back({1'b1, 5'd0, 32'h0000_4180});
    end else begin
      exp_q.push_back({1'b1, 5'd0, epc});
    end
    exc_req  = is_exc;
    eret_req = !is_exc || both;
    exc_code = code;
    exc_pc   = pc;
    n = is_exc ? 6 : 5;
    for (int k = 1; k <= n; k++) begin
      tick();
      // pattern = {busy, cp0_r, cp0_w, done, cp0_raddr}
      if (k == 1)                 pe = {4'b1100, 5'd12};
      else if (is_exc && k <= 4)  pe = {4'b1010, 5'd0};
      else if (is_exc && k == 5)  pe = {4'b1001, 5'd0};
      else if (!is_exc && k == 2) pe = {4'b1010, 5'd0};
      else if (!is_exc && k == 3) pe = {4'b1100, 5'd14};
      else if (!is_exc && k == 4) pe = {4'b1001, 5'd0};
      else                        pe = 9'd0;
      check(is_exc ? "exc_pattern" : "eret_pattern",
            {71'd0, busy, cp0_r, cp0_w, done, cp0_raddr}, {71'd0, pe});
      if (k == 1) begin
        exc_req  = 1'b0;
        eret_req = 1'b0;
      end
      if (k == 2) eret_req = inject;
      if (k == 4) eret_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst = 1'b0; exc_req = 1'b0; eret_req = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
    #2;
    check("reset_outputs", all_outs(), 80'd0);
    tick();
    check("reset_held", all_outs(), 80'd0);
    rst = 1'b1;
    tick();

    run_seq(1'b1, 1'b0, 1'b0, 5'd8, 32'h0040_0010, 32'h0000_000F, 32'd0, 32'h0000_01E0);
    run_seq(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_01E0, 32'h0040_0010, 32'h0000_000F);
    run_seq(1'b1, 1'b0, 1'b0, 5'd9, 32'h0040_0100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFE0);
    run_seq(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h07FF_FFFF);
    run_seq(1'b1, 1'b1, 1'b0, 5'd13, 32'h0040_0200, 32'h0000_0003, 32'd0, 32'h0000_0060);
    run_seq(1'b1, 1'b0, 1'b1, 5'd8, 32'h0040_0300, 32'h0000_0001, 32'd0, 32'h0000_0020);
    check("back_in_idle", all_outs(), 80'd0);

    // Abort an exception while Cause is being driven.
    regs[12] = 32'h0000_000A;
    regs[13] = 32'hDEAD_BEEF;
    exp_q.push_back({1'b0, 5'd12, 32'h0000_0140});
    exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0400;
    tick();
    exc_req = 1'b0;
    tick();
    @(posedge clk);
    #1;
    check("pre_abort_cause_strobe", {74'd0, cp0_w, cp0_waddr}, {74'd0, 1'b1, 5'd13});
    rst = 1'b0;
    #1;
    check("abort_outputs", all_outs(), 80'd0);
    tick();
    check("abort_held", all_outs(), 80'd0);
    rst = 1'b1;
    check("cause_untouched", {48'd0, regs[13]}, {48'd0, 32'hDEAD_BEEF});
    tick();
    run_seq(1'b1, 1'b0, 1'b0, 5'd13, 32'h0040_0500, 32'h0000_0002, 32'd0, 32'h0000_0040);

    check("scoreboard_drained", 80'(exp_q.size()), 80'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
